dds_mod_controller: RTL and testbench



---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_mod_controller_lfsr_gen.sv | 34 +++
 rtl/dds_mod_controller.sv | 146 ++++++++++++++
 tb/tb_dds_mod_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS modulation controller.
package dds_pkg;

    typedef enum logic [1:0] {
        SIG_SIN    = 2'b00,
        SIG_COS    = 2'b01,
        SIG_SAW    = 2'b10,
        SIG_SQUARE = 2'b11
    } sig_sel_t;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'b00,
        MOD_FSK  = 2'b01,
        MOD_BPSK = 2'b10,
        MOD_LFSR = 2'b11
    } mod_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] LFSR_SEED = 5'b00001;
    localparam int         LFSR_TAP  = 2;

endpackage

// File: rtl/dds_mod_controller_lfsr_gen.sv
// 5-bit Fibonacci LFSR (x^5+x^3+1) that advances on step_i and
// recovers to the seed if it ever lands in the all-zero lock-up state.
module lfsr_gen
    import dds_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_i,
    output logic [4:0] lfsr_o
);

    logic [4:0] lfsr_q, lfsr_d;

    // Zero recovery wins over stepping so the register can never stay stuck.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == 5'b00000) begin
            lfsr_d = LFSR_SEED;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[LFSR_TAP], lfsr_q[4:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dds_mod_controller.sv
// DDS waveform/modulation sequencer: synchronizes switch requests, applies them
// glitch-free at phase-accumulator wraps, and produces the LFSR modulating bit.
module dds_mod_controller
    import dds_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned WRAP_TIMEOUT = 1024,
    parameter int unsigned HOLD_CYC     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sig_sel_req,
    input  logic [1:0] mod_sel_req,
    input  logic       phase_wrap,
    output logic [1:0] sig_sel,
    output logic [1:0] mod_sel,
    output logic       en,
    output logic [4:0] lfsr,
    output logic       tick,
    output logic       busy
);

    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam int unsigned TO_W   = $clog2(WRAP_TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(WRAP_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic [3:0]        reqSync1_q, reqSync2_q;
    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic              tick_q;
    logic [4:0]        lfsrVal;
    logic              en_q;
    ctrl_state_t       state_q, state_d;
    logic [3:0]        shadow_q, shadow_d;
    logic [3:0]        applied_q, applied_d;
    logic [TO_W-1:0]   toCnt_q, toCnt_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqSync1_q <= 4'b0000;
            reqSync2_q <= 4'b0000;
        end else begin
            reqSync1_q <= {sig_sel_req, mod_sel_req};
            reqSync2_q <= reqSync1_q;
        end
    end

    // tick is registered against the next count so it is high exactly while the count sits at its last value.
    assign divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            tick_q   <= (divCnt_d == DIV_LAST);
        end
    end

    lfsr_gen u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .step_i (tick_q),
        .lfsr_o (lfsrVal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= 1'b1;
        end else if (phase_wrap) begin
            en_q <= lfsrVal[0];
        end
    end

    // A wrap or timeout applies the shadow before any cancel or shadow refresh is considered.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        applied_d = applied_q;
        toCnt_d   = toCnt_q;
        holdCnt_d = holdCnt_q;
        case (state_q)
            IDLE: begin
                if (reqSync2_q != applied_q) begin
                    shadow_d = reqSync2_q;
                    toCnt_d  = '0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (phase_wrap || (toCnt_q == TO_LAST)) begin
                    applied_d = shadow_q;
                    holdCnt_d = '0;
                    state_d   = HOLD;
                end else if (reqSync2_q == applied_q) begin
                    state_d = IDLE;
                end else begin
                    if (reqSync2_q != shadow_q) begin
                        shadow_d = reqSync2_q;
                    end
                    toCnt_d = toCnt_q + TO_W'(1);
                end
            end
            HOLD: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    holdCnt_d = holdCnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= 4'b0000;
            applied_q <= 4'b0000;
            toCnt_q   <= '0;
            holdCnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            applied_q <= applied_d;
            toCnt_q   <= toCnt_d;
            holdCnt_q <= holdCnt_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign sig_sel = applied_q[3:2];
    assign mod_sel = applied_q[1:0];
    assign en      = en_q;
    assign lfsr    = lfsrVal;
    assign tick    = tick_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dds_mod_controller.sv
// Self-checking bench for dds_mod_controller: reset/LFSR sequencing, wrap-aligned
// applies, latest-wins/cancel, HOLD behaviour, en timing and wrap timeout.
module tb_dds_mod_controller;
    import dds_pkg::*;

    localparam int TD    = 8;
    localparam int WT    = 32;
    localparam int WT_TO = 16;
    localparam int HC    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sigReq = 2'b00;
    logic [1:0] modReq = 2'b00;
    logic       phaseWrap = 1'b0;

    logic [1:0] sigSel, modSel, sigSelB, modSelB;
    logic       en, enB, tick, tickB, busy, busyB;
    logic [4:0] lfsr, lfsrB;

    int vecCount = 0;
    int missCount = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] sig;
        logic [1:0] mod;
        int         wrapAt;
        logic [3:0] expSel;
        logic       expBusy;
    } vec_t;
    vec_t vecs[6];

    logic [4:0] lfsrSeq[31];
    int         sinceRst;
    logic       modelEn;

    always #5 clk = ~clk;

    dds_mod_controller #(.TICK_DIV(TD), .WRAP_TIMEOUT(WT), .HOLD_CYC(HC)) dut (
        .clk(clk), .reset(reset), .sig_sel_req(sigReq), .mod_sel_req(modReq),
        .phase_wrap(phaseWrap), .sig_sel(sigSel), .mod_sel(modSel), .en(en),
        .lfsr(lfsr), .tick(tick), .busy(busy)
    );

    dds_mod_controller #(.TICK_DIV(TD), .WRAP_TIMEOUT(WT_TO), .HOLD_CYC(HC)) dutTo (
        .clk(clk), .reset(reset), .sig_sel_req(sigReq), .mod_sel_req(modReq),
        .phase_wrap(phaseWrap), .sig_sel(sigSelB), .mod_sel(modSelB), .en(enB),
        .lfsr(lfsrB), .tick(tickB), .busy(busyB)
    );

    // Reference for en: cycles since reset select the LFSR sequence entry live before each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sinceRst <= 0;
            modelEn  <= 1'b1;
        end else begin
            if (phaseWrap) modelEn <= lfsrSeq[(sinceRst / TD) % 31][0];
            sinceRst <= sinceRst + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic popCheck(input logic [7:0] actual);
        exp_t e;
        if (sb.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL scoreboard_empty: got %0h, expected a queued value", actual);
        end else begin
            e = sb.pop_front();
            checkOutput(e.name, actual, e.exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sigReq = v.sig;
        modReq = v.mod;
        sb.push_back('{"busy_armed", 8'(v.expBusy)});
        sb.push_back('{"sel_applied", 8'(v.expSel)});
        repeat (v.wrapAt - 1) @(negedge clk);
        popCheck(8'(busy));
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        popCheck(8'({sigSel, modSel}));
        checkOutput("en_vec", 8'(en), 8'(modelEn));
        repeat (HC) @(negedge clk);
        checkOutput("busy_idle", 8'(busy), 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   idx;
        logic preBit;
        bit   found;

        vecs[0] = '{SIG_SIN,    MOD_FSK,  6,  4'b0001, 1'b1};
        vecs[1] = '{SIG_SQUARE, MOD_LFSR, 10, 4'b1111, 1'b1};
        vecs[2] = '{SIG_SQUARE, MOD_LFSR, 6,  4'b1111, 1'b0};
        vecs[3] = '{SIG_COS,    MOD_ASK,  30, 4'b0100, 1'b1};
        vecs[4] = '{SIG_SAW,    MOD_FSK,  4,  4'b1001, 1'b1};
        vecs[5] = '{SIG_SIN,    MOD_ASK,  8,  4'b0000, 1'b1};

        lfsrSeq[0] = LFSR_SEED;
        for (int i = 1; i < 31; i++)
            lfsrSeq[i] = {lfsrSeq[i-1][0] ^ lfsrSeq[i-1][2], lfsrSeq[i-1][4:1]};

        // Reset asserted mid-count while a request is pending.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sigReq = SIG_SAW;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_sig", 8'(sigSel), 8'h00);
        checkOutput("rst_mod", 8'(modSel), 8'h00);
        checkOutput("rst_lfsr", 8'(lfsr), 8'h01);
        checkOutput("rst_en", 8'(en), 8'h01);
        checkOutput("rst_tick", 8'(tick), 8'h00);
        checkOutput("rst_busy", 8'(busy), 8'h00);
        sigReq = SIG_SIN;
        @(negedge clk);
        checkOutput("rst_hold_busy", 8'(busy), 8'h00);
        checkOutput("rst_hold_lfsr", 8'(lfsr), 8'h01);
        reset = 1'b0;

        for (int k = 1; k <= 31 * TD; k++) begin
            @(negedge clk);
            checkOutput("tick", 8'(tick), 8'((k % TD) == TD - 1));
            if (k % TD == 0) checkOutput("lfsr_seq", 8'(lfsr), 8'(lfsrSeq[(k / TD) % 31]));
            if (k == 31 * TD) checkOutput("lfsr_period", 8'(lfsr), 8'(LFSR_SEED));
        end

        // Wrap-aligned apply.
        sigReq = SIG_SAW;
        modReq = MOD_BPSK;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 2) checkOutput("busy_pre", 8'(busy), 8'h00);
            if (k == 3) checkOutput("busy_rise", 8'(busy), 8'h01);
        end
        checkOutput("sel_before_wrap", 8'({sigSel, modSel}), 8'h00);
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_wrap_apply", 8'({sigSel, modSel}), 8'h0A);
        checkOutput("en_wrap", 8'(en), 8'(modelEn));
        for (int k = 1; k <= HC; k++) begin
            @(negedge clk);
            checkOutput("busy_hold", 8'(busy), 8'(k < HC));
        end

        // Latest request wins while armed.
        sigReq = SIG_SQUARE;
        repeat (5) @(negedge clk);
        sigReq = SIG_COS;
        repeat (3) @(negedge clk);
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_latest", 8'({sigSel, modSel}), 8'h06);
        repeat (HC) @(negedge clk);
        checkOutput("busy_latest_idle", 8'(busy), 8'h00);

        // Cancel by returning to the applied value.
        sigReq = SIG_SIN;
        repeat (5) @(negedge clk);
        checkOutput("busy_cancel_armed", 8'(busy), 8'h01);
        sigReq = SIG_COS;
        repeat (2) @(negedge clk);
        checkOutput("busy_cancel_pending", 8'(busy), 8'h01);
        @(negedge clk);
        checkOutput("busy_cancel", 8'(busy), 8'h00);
        checkOutput("sel_cancel", 8'({sigSel, modSel}), 8'h06);
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_idle_wrap", 8'({sigSel, modSel}), 8'h06);

        // Tick and wrap in the same cycle, on a step where lfsr[0] flips.
        found = 1'b0;
        for (int n = 0; n < 31 * TD && !found; n++) begin
            if ((sinceRst % TD == TD - 1) &&
                (lfsrSeq[(sinceRst / TD) % 31][0] != lfsrSeq[(sinceRst / TD + 1) % 31][0]))
                found = 1'b1;
            else
                @(negedge clk);
        end
        if (!found) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL tick_search: got no usable tick, expected one within %0d cycles", 31 * TD);
        end else begin
            idx = (sinceRst / TD) % 31;
            preBit = lfsrSeq[idx][0];
            checkOutput("tick_coincide", 8'(tick), 8'h01);
            phaseWrap = 1'b1;
            @(negedge clk);
            phaseWrap = 1'b0;
            checkOutput("en_pre_advance", 8'(en), 8'(preBit));
            checkOutput("lfsr_advanced", 8'(lfsr), 8'(lfsrSeq[(idx + 1) % 31]));
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                checkOutput("en_stable", 8'(en), 8'(preBit));
            end
        end

        // Requests during HOLD are ignored, then picked up right after.
        sigReq = SIG_SAW;
        repeat (4) @(negedge clk);
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_hold_entry", 8'({sigSel, modSel}), 8'h0A);
        sigReq = SIG_SIN;
        modReq = MOD_ASK;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            checkOutput("busy_hold_req", 8'(busy), 8'(j != 4));
            if (j <= 4) checkOutput("sel_in_hold", 8'({sigSel, modSel}), 8'h0A);
        end
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_after_hold", 8'({sigSel, modSel}), 8'h00);
        repeat (HC) @(negedge clk);

        // Wrap coinciding with a shadow refresh applies the old shadow.
        sigReq = SIG_SQUARE;
        repeat (5) @(negedge clk);
        sigReq = SIG_SAW;
        repeat (2) @(negedge clk);
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_old_shadow", 8'({sigSel, modSel}), 8'h0C);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j >= 4) checkOutput("busy_rearm", 8'(busy), 8'(j == 5));
        end
        phaseWrap = 1'b1;
        @(negedge clk);
        phaseWrap = 1'b0;
        checkOutput("sel_new_shadow", 8'({sigSel, modSel}), 8'h08);
        repeat (HC) @(negedge clk);

        for (int v = 0; v < 6; v++) applyStimulus(vecs[v]);

        // Timeout with no wrap: short-timeout instance applies at 16, main at 32.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sigReq = SIG_SQUARE;
        modReq = MOD_ASK;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 18) checkOutput("to16_before", 8'({sigSelB, modSelB}), 8'h00);
            if (k == 19) checkOutput("to16_apply", 8'({sigSelB, modSelB}), 8'h0C);
            if (k == 19) checkOutput("to16_busy", 8'(busyB), 8'h01);
            if (k == 34) checkOutput("to32_before", 8'({sigSel, modSel}), 8'h00);
            if (k == 35) checkOutput("to32_apply", 8'({sigSel, modSel}), 8'h0C);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
